// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: 2-flop sync, per-channel glitch filter, INIT/RUN FSM, registered step/dir/err.
// Edge sampled at k pulses after edge k+FILT_LEN+2; define QUAD_ERR_CNT_EN for a saturating err_count port.
module quad_step_decoder #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_in,
    input  logic       b_in,
    output logic       enable,
    output logic       direction,
    output logic       err
`ifdef QUAD_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);
    localparam logic [7:0] FILT_MAX  = 8'(FILT_LEN - 1);
    localparam logic [8:0] INIT_LAST = 9'(FILT_LEN + 1);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
    state_t state_q, state_d;

    logic       a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic       a_f_q, a_f_d, b_f_q, b_f_d;
    logic [7:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic [8:0] init_cnt_q, init_cnt_d;
    logic [1:0] prev_q, delta;
    logic       enable_q, enable_d, dir_q, dir_d, err_q, err_d;

    // Returns {filtered_next, count_next}.
    function automatic logic [8:0] filt_next(input logic s2, input logic f, input logic [7:0] cnt);
        if (s2 == f)
            return {f, 8'd0};
        else if (cnt == FILT_MAX)
            return {s2, 8'd0};
        else
            return {f, cnt + 8'd1};
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_INIT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_cnt_q == INIT_LAST)
            state_d = ST_RUN;
    end

    // INIT copies the synchronised inputs straight through so a non-00 rest state is absorbed silently.
    always_comb begin
        a_f_d      = a_s2_q;
        b_f_d      = b_s2_q;
        a_cnt_d    = 8'd0;
        b_cnt_d    = 8'd0;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 9'd1;
        end else begin
            {a_f_d, a_cnt_d} = filt_next(a_s2_q, a_f_q, a_cnt_q);
            {b_f_d, b_cnt_d} = filt_next(b_s2_q, b_f_q, b_cnt_q);
        end
    end

    assign delta = prev_q ^ {a_f_q, b_f_q};

    always_comb begin
        enable_d = 1'b0;
        err_d    = 1'b0;
        dir_d    = dir_q;
        if (state_q == ST_RUN) begin
            case (delta)
                2'b11: err_d = 1'b1;
                2'b10, 2'b01: begin
                    enable_d = 1'b1;
                    // Up order 00->10->11->01: an A change lands on a!=b, a B change on a==b.
                    dir_d    = delta[1] ? (a_f_q ^ b_f_q) : ~(a_f_q ^ b_f_q);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_s1_q     <= 1'b0;
            a_s2_q     <= 1'b0;
            b_s1_q     <= 1'b0;
            b_s2_q     <= 1'b0;
            a_f_q      <= 1'b0;
            b_f_q      <= 1'b0;
            a_cnt_q    <= 8'd0;
            b_cnt_q    <= 8'd0;
            init_cnt_q <= 9'd0;
            prev_q     <= 2'b00;
            enable_q   <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            a_s1_q     <= a_in;
            a_s2_q     <= a_s1_q;
            b_s1_q     <= b_in;
            b_s2_q     <= b_s1_q;
            a_f_q      <= a_f_d;
            b_f_q      <= b_f_d;
            a_cnt_q    <= a_cnt_d;
            b_cnt_q    <= b_cnt_d;
            init_cnt_q <= init_cnt_d;
            prev_q     <= {a_f_q, b_f_q};
            enable_q   <= enable_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    assign enable    = enable_q;
    assign direction = dir_q;
    assign err       = err_q;

`ifdef QUAD_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_q && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt_q <= 8'd0;
        else
            err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder (FILT_LEN=4): segment table plus reset and error-count sequences.
module tb_quad_step_decoder;
    logic clk = 1'b0;
    logic rst;
    logic a_in, b_in;
    logic enable, direction, err;
`ifdef QUAD_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] mdl_ctr = 8'd0;

    always #5 clk = ~clk;

    quad_step_decoder #(.FILT_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .enable    (enable),
        .direction (direction),
        .err       (err)
`ifdef QUAD_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    // One segment: hold {a,b} for 'hold' cycles; expected pulse counts, first-pulse offset, final direction,
    // and the value of a downstream 8-bit up/down counter driven by enable/direction.
    typedef struct {
        logic       a;
        logic       b;
        int         hold;
        int         n_en;
        int         n_err;
        logic       dir;
        int         off;
        logic [7:0] ctr;
    } seg_t;

    seg_t tbl[15];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic run_seg(input seg_t s, input string tag);
        int n_en   = 0;
        int n_err  = 0;
        int n_both = 0;
        int off    = -1;
        a_in = s.a;
        b_in = s.b;
        for (int j = 0; j < s.hold; j++) begin
            @(posedge clk); #1;
            if (enable) begin
                n_en++;
                mdl_ctr = direction ? mdl_ctr + 8'd1 : mdl_ctr - 8'd1;
            end
            if (err) n_err++;
            if (enable && err) n_both++;
            if ((enable || err) && off < 0) off = j;
        end
        check({tag, ".en_pulses"},  n_en,       s.n_en);
        check({tag, ".err_pulses"}, n_err,      s.n_err);
        check({tag, ".en_and_err"}, n_both,     0);
        check({tag, ".first_off"},  off,        s.off);
        check({tag, ".direction"},  int'(direction), int'(s.dir));
        check({tag, ".counter"},    int'(mdl_ctr),   int'(s.ctr));
    endtask

    initial begin
        // Down sequence from 00, then up steps, glitch rejection, minimum-width pulse, illegal jumps.
        tbl[0]  = '{1'b0, 1'b1, 10, 1, 0, 1'b0,  6, 8'd255};
        tbl[1]  = '{1'b1, 1'b1, 10, 1, 0, 1'b0,  6, 8'd254};
        tbl[2]  = '{1'b1, 1'b0, 10, 1, 0, 1'b0,  6, 8'd253};
        tbl[3]  = '{1'b0, 1'b0, 10, 1, 0, 1'b0,  6, 8'd252};
        tbl[4]  = '{1'b1, 1'b0, 20, 1, 0, 1'b1,  6, 8'd253};
        tbl[5]  = '{1'b1, 1'b1, 20, 1, 0, 1'b1,  6, 8'd254};
        tbl[6]  = '{1'b0, 1'b1, 10, 1, 0, 1'b1,  6, 8'd255};
        tbl[7]  = '{1'b0, 1'b0, 10, 1, 0, 1'b1,  6, 8'd0};
        tbl[8]  = '{1'b1, 1'b0,  3, 0, 0, 1'b1, -1, 8'd0};
        tbl[9]  = '{1'b0, 1'b0, 10, 0, 0, 1'b1, -1, 8'd0};
        tbl[10] = '{1'b1, 1'b0,  4, 0, 0, 1'b1, -1, 8'd0};
        tbl[11] = '{1'b0, 1'b0, 12, 2, 0, 1'b0,  2, 8'd0};
        tbl[12] = '{1'b1, 1'b1, 10, 0, 1, 1'b0,  6, 8'd0};
        tbl[13] = '{1'b0, 1'b0, 10, 0, 1, 1'b0,  6, 8'd0};
        tbl[14] = '{1'b1, 1'b0, 10, 1, 0, 1'b1,  6, 8'd1};

        // Power-up with the encoder resting at 11.
        rst  = 1'b1;
        a_in = 1'b1;
        b_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst%0d.enable", i),    int'(enable),    0);
            check($sformatf("rst%0d.err", i),       int'(err),       0);
            check($sformatf("rst%0d.direction", i), int'(direction), 0);
        end
        rst = 1'b0;
        run_seg('{1'b1, 1'b1, 20, 0, 0, 1'b0, -1, 8'd0}, "pwr11_quiet");
        run_seg('{1'b0, 1'b1, 10, 1, 0, 1'b1,  6, 8'd1}, "pwr11_up1");
        run_seg('{1'b0, 1'b0, 10, 1, 0, 1'b1,  6, 8'd2}, "pwr11_up2");

        // Re-initialise at 00 for the table.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst00_%0d.enable", i),    int'(enable),    0);
            check($sformatf("rst00_%0d.direction", i), int'(direction), 0);
        end
        rst = 1'b0;
        run_seg('{1'b0, 1'b0, 10, 0, 0, 1'b0, -1, 8'd2}, "pwr00_quiet");
        mdl_ctr = 8'd0;

        for (int i = 0; i < 15; i++) begin
            run_seg(tbl[i], $sformatf("row%0d", i));
`ifdef QUAD_ERR_CNT_EN
            if (i == 13) check("row13.err_count", int'(err_count), 2);
`endif
        end

        // Reset while channel B's filter count sits at 2 (f=10, B pending rise).
        run_seg('{1'b1, 1'b1, 4, 0, 0, 1'b1, -1, 8'd1}, "midrst_pre");
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst.enable",    int'(enable),    0);
        check("midrst.err",       int'(err),       0);
        check("midrst.direction", int'(direction), 0);
`ifdef QUAD_ERR_CNT_EN
        check("midrst.err_count", int'(err_count), 0);
`endif
        rst = 1'b0;
        run_seg('{1'b1, 1'b1, 20, 0, 0, 1'b0, -1, 8'd1}, "midrst_quiet");
        run_seg('{1'b0, 1'b1, 10, 1, 0, 1'b1,  6, 8'd2}, "midrst_up");

`ifdef QUAD_ERR_CNT_EN
        begin
            int n_err_seen = 0;
            int n_en_seen  = 0;
            for (int i = 0; i < 300; i++) begin
                a_in = (i % 2 == 0) ? 1'b1 : 1'b0;
                b_in = ~a_in;
                for (int j = 0; j < 10; j++) begin
                    @(posedge clk); #1;
                    if (err)    n_err_seen++;
                    if (enable) n_en_seen++;
                end
                if (i == 253) check("errcnt.at254", int'(err_count), 254);
                if (i == 254) check("errcnt.at255", int'(err_count), 255);
            end
            check("errcnt.err_pulses", n_err_seen, 300);
            check("errcnt.en_pulses",  n_en_seen,  0);
            check("errcnt.saturated",  int'(err_count), 255);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
